// File: rtl/adder2_bist.sv
// -----------------------------------------------------------------------------
// adder2_bist
//
// Built-in self-test engine for a WIDTH-bit adder. On a start pulse it sweeps
// every operand pair (a outer, b inner), holds each pair for SETTLE cycles,
// then compares the returned sum y against (a+b) mod 2^WIDTH for one cycle.
// It reports pass/fail, a saturating mismatch count and the first failing
// vector.
//
// Optional build macro:
//   ADDER2_BIST_STOP_ON_FAIL_EN  - when defined, the first mismatch ends the
//                                  sweep immediately and a/b stay on the
//                                  failing vector.
//
// Parameters:
//   WIDTH   operand/sum width (vectors swept = 2^(2*WIDTH))
//   SETTLE  cycles a/b are held before y is sampled (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   single-cycle pulse, begins a sweep when idle
//   a, b       out  operands driven to the adder
//   y          in   sum returned by the adder
//   busy       out  high while the sweep runs (DRIVE/CHECK)
//   done       out  one-cycle pulse when the sweep ends
//   pass       out  high after done if no mismatch, held until next start
//   err_count  out  number of mismatching vectors, saturating
//   fail_a/b/y out  operands and observed sum of the first mismatch
//
// States:
//   IDLE   | waiting for start, a/b hold their last values
//   DRIVE  | a/b applied, waiting SETTLE cycles for the adder to settle
//   CHECK  | one cycle: compare y, update error info, advance vector
//   FINISH | one cycle: done pulse, pass valid
// -----------------------------------------------------------------------------
module adder2_bist #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic [WIDTH-1:0]   fail_y
);

    localparam int EW = 2 * WIDTH + 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [EW-1:0] ERR_MAX  = {EW{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        CHECK  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [EW-1:0]    err_q, err_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [WIDTH-1:0] fy_q, fy_d;

    logic [WIDTH-1:0] sum_exp;
    logic             mismatch;
    logic             last_vec;
    logic [EW-1:0]    err_inc;

    // Carry is intentionally dropped: the adder under test returns WIDTH bits.
    assign sum_exp  = a_q + b_q;
    assign mismatch = (y != sum_exp);
    assign last_vec = (&a_q) & (&b_q);
    assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + EW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fy_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fy_q    <= fy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        pass_d  = pass_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fy_d    = fy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    b_d     = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fy_d    = '0;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            CHECK: begin
                if (mismatch) begin
                    err_d = err_inc;
                    // err_q still zero means this is the first failing vector.
                    if (err_q == '0) begin
                        fa_d = a_q;
                        fb_d = b_q;
                        fy_d = y;
                    end
                end
`ifdef ADDER2_BIST_STOP_ON_FAIL_EN
                if (mismatch || last_vec) begin
`else
                if (last_vec) begin
`endif
                    // pass must reflect this final compare, so use err_d.
                    pass_d  = (err_d == '0);
                    state_d = FINISH;
                end else begin
                    b_d = b_q + WIDTH'(1);
                    if (&b_q) begin
                        a_d = a_q + WIDTH'(1);
                    end
                    state_d = DRIVE;
                end
            end

            FINISH: begin
                // Unconditional: a start coinciding with done is dropped.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == DRIVE) || (state_q == CHECK);
    assign done      = (state_q == FINISH);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_a    = fa_q;
    assign fail_b    = fb_q;
    assign fail_y    = fy_q;

endmodule

// File: tb/tb_adder2_bist.sv
module tb_adder2_bist;

    localparam int W  = 2;
    localparam int S  = 1;
    localparam int NV = 16;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a, b, y;
    logic           busy, done, pass;
    logic [2*W:0]   err_count;
    logic [W-1:0]   fail_a, fail_b, fail_y;

    // Adder stand-in: y is a lookup on {a,b}, so faults are just table edits.
    logic [W-1:0]   ytab [NV];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    adder2_bist #(.WIDTH(W), .SETTLE(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_y    (fail_y)
    );

    assign y = ytab[{a, b}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int correct_sum(input int v);
        return ((v / 4) + (v % 4)) % 4;
    endfunction

    function automatic bit is_bad(input int v);
        return int'(ytab[v]) != correct_sum(v);
    endfunction

    // ---------------- behavioural model ----------------
    // m_t is the cycle number since the start was accepted (1 = first DRIVE).
    bit m_valid = 0;
    bit m_phase = 0;
    int m_t = 0, m_end = 0;
    int h_a, h_b, h_err, h_pass, h_fa, h_fb, h_fy;

    task automatic plan();
        int first, tot, lastv;
        first = -1;
        tot   = 0;
        for (int v = 0; v < NV; v++) begin
            if (is_bad(v)) begin
                if (first < 0) first = v;
                tot++;
            end
        end
        lastv = NV - 1;
        m_end = NV * (S + 1) + 1;
`ifdef ADDER2_BIST_STOP_ON_FAIL_EN
        if (first >= 0) begin
            lastv = first;
            m_end = (first + 1) * (S + 1) + 1;
            tot   = 1;
        end
`endif
        h_a    = lastv / 4;
        h_b    = lastv % 4;
        h_err  = tot;
        h_pass = (tot == 0);
        h_fa   = (first >= 0) ? first / 4 : 0;
        h_fb   = (first >= 0) ? first % 4 : 0;
        h_fy   = (first >= 0) ? int'(ytab[first]) : 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_phase = 0;
            m_t     = 0;
            h_a = 0; h_b = 0; h_err = 0; h_pass = 0; h_fa = 0; h_fb = 0; h_fy = 0;
        end else if (m_valid) begin
            if (m_phase) begin
                m_t++;
                if (m_t > m_end) m_phase = 0;
            end else if (start) begin
                m_phase = 1;
                m_t     = 1;
                plan();
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int e_a, e_b, e_busy, e_done, e_pass, e_err, e_fa, e_fb, e_fy;
            int v, first;
            e_a = h_a; e_b = h_b; e_busy = 0; e_done = 0; e_pass = h_pass;
            e_err = h_err; e_fa = h_fa; e_fb = h_fb; e_fy = h_fy;
            if (m_phase && m_t == m_end) begin
                e_done = 1;
            end else if (m_phase) begin
                v      = (m_t - 1) / (S + 1);
                e_a    = v / 4;
                e_b    = v % 4;
                e_busy = 1;
                e_pass = 0;
                e_err  = 0;
                first  = -1;
                for (int k = 0; k < v; k++) begin
                    if (is_bad(k)) begin
                        if (first < 0) first = k;
                        e_err++;
                    end
                end
                e_fa = (first >= 0) ? first / 4 : 0;
                e_fb = (first >= 0) ? first % 4 : 0;
                e_fy = (first >= 0) ? int'(ytab[first]) : 0;
            end
            chk("busy",      int'(busy),      e_busy);
            chk("done",      int'(done),      e_done);
            chk("a",         int'(a),         e_a);
            chk("b",         int'(b),         e_b);
            chk("pass",      int'(pass),      e_pass);
            chk("err_count", int'(err_count), e_err);
            chk("fail_a",    int'(fail_a),    e_fa);
            chk("fail_b",    int'(fail_b),    e_fb);
            chk("fail_y",    int'(fail_y),    e_fy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_correct();
        for (int v = 0; v < NV; v++) ytab[v] = W'(correct_sum(v));
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
    endtask

    // Optionally re-pulses start while we sit in cycles p1 / p2 of the sweep.
    task automatic wait_done(input int p1, input int p2);
        while (!done && cyc < 300) begin
            if (cyc == p1 || cyc == p2) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            cyc++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        set_correct();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_err",  int'(err_count), 0);
        chk("rst_pass", int'(pass), 0);

        // Good adder
        do_start();
        wait_done(-1, -1);
        chk("good_latency", cyc, 33);
        chk("good_pass", int'(pass), 1);
        chk("good_err", int'(err_count), 0);
        chk("good_last_a", int'(a), 3);
        chk("good_last_b", int'(b), 3);

        // Single fault at 01+10
        ytab[6] = 2'b00;
        do_start();
        wait_done(-1, -1);
`ifdef ADDER2_BIST_STOP_ON_FAIL_EN
        chk("single_latency", cyc, 15);
`else
        chk("single_latency", cyc, 33);
`endif
        chk("single_pass", int'(pass), 0);
        chk("single_err", int'(err_count), 1);
        chk("single_fa", int'(fail_a), 1);
        chk("single_fb", int'(fail_b), 2);
        chk("single_fy", int'(fail_y), 0);

        // y stuck at 00
        for (int v = 0; v < NV; v++) ytab[v] = 2'b00;
        do_start();
        wait_done(-1, -1);
`ifdef ADDER2_BIST_STOP_ON_FAIL_EN
        chk("stuck_latency", cyc, 5);
        chk("stuck_err", int'(err_count), 1);
        chk("stuck_hold_a", int'(a), 0);
        chk("stuck_hold_b", int'(b), 1);
`else
        chk("stuck_latency", cyc, 33);
        chk("stuck_err", int'(err_count), 12);
`endif
        chk("stuck_pass", int'(pass), 0);
        chk("stuck_fa", int'(fail_a), 0);
        chk("stuck_fb", int'(fail_b), 1);
        chk("stuck_fy", int'(fail_y), 0);

        // Reset in cycle 10 of a sweep
        set_correct();
        do_start();
        while (cyc < 10) begin @(posedge clk); #1 cyc++; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_a", int'(a), 0);
        chk("abort_b", int'(b), 0);
        chk("abort_err", int'(err_count), 0);
        repeat (40) @(posedge clk);
        #1;
        do_start();
        wait_done(-1, -1);
        chk("after_abort_latency", cyc, 33);

        // Spurious starts at cycles 5 and 20 are ignored
        do_start();
        wait_done(5, 20);
        chk("restart_ignored_latency", cyc, 33);
        chk("restart_ignored_pass", int'(pass), 1);

        // start during FINISH dropped, start in next IDLE accepted
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 1;
        chk("idle_start_busy", int'(busy), 1);
        wait_done(-1, -1);
        chk("idle_start_latency", cyc, 33);

        // Random fault tables
        for (int r = 0; r < 6; r++) begin
            for (int v = 0; v < NV; v++) begin
                if ($urandom_range(3) == 0)
                    ytab[v] = W'(correct_sum(v) + int'($urandom_range(1, 3)));
                else
                    ytab[v] = W'(correct_sum(v));
            end
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            do_start();
            wait_done(-1, -1);
            chk("rand_latency", cyc, m_end);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/adder2_bist.md
Name: adder2_bist

Overview:
- Built-in self-test engine for the 2-bit adder. It is the hardware counterpart of the stimulus side: it generates vectors and also checks responses.
- Drives operands a/b into the adder, samples its sum y, and compares against (a+b) mod 2^WIDTH.
- Sweeps all operand pairs exhaustively: a is the outer loop, b the inner loop, 00..11 each.
- Reports pass/fail, error count and first failing vector. Sits beside the adder; started by a single-cycle start pulse.

Parameters:
- WIDTH, 2, operand/sum width; total vectors = 2^(2*WIDTH).
- SETTLE, 1, clock cycles a/b are held before y is sampled (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a sweep when idle.
- a  output  WIDTH  operand A to adder.
- b  output  WIDTH  operand B to adder.
- y  input  WIDTH  sum returned by adder.
- busy  output  1  high while the sweep runs.
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  high after done if err_count==0; held until next start.
- err_count  output  2*WIDTH+1  number of mismatching vectors, saturating.
- fail_a  output  WIDTH  a of first mismatch.
- fail_b  output  WIDTH  b of first mismatch.
- fail_y  output  WIDTH  y observed at first mismatch.

Behaviour:
- Reset: synchronous, active-high on clk. All outputs are 0; state=IDLE; settle counter=0.
- FSM states: IDLE, DRIVE, CHECK, FINISH.
- IDLE:
  - a/b hold their last values.
  - start=1 -> a=0, b=0, err_count=0, pass=0, fail_*=0, busy=1, go to DRIVE.
- DRIVE:
  - Hold a/b for SETTLE cycles (counter from 0 to SETTLE-1), then go to CHECK.
- CHECK (exactly one cycle):
  - Compare y with (a+b) truncated to WIDTH bits; carry is discarded.
  - On mismatch: err_count += 1, saturating at all-ones. If this is the first mismatch, latch fail_a/fail_b/fail_y.
  - Last vector (a and b both all-ones) -> FINISH.
  - Otherwise b += 1. When b wraps to 0, a += 1. Go to DRIVE.
- FINISH (one cycle):
  - done=1; pass=(err_count==0), computed including the final check; busy=0; go to IDLE.
- Timing:
  - Sweep latency from start to done: 2^(2*WIDTH)*(SETTLE+1)+1 cycles. WIDTH=2, SETTLE=1: 33 cycles.
  - done is asserted exactly one cycle and never coincides with busy.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as done/FINISH is ignored. A start in the following IDLE cycle is accepted.
  - rst mid-sweep aborts immediately to the reset state; no done pulse.
  - a/b change only on the CHECK->DRIVE transition or at start, so the adder sees stable inputs for SETTLE+1 cycles per vector.
  - err_count maximum is 2^(2*WIDTH); the width holds this without saturating in practice. Saturation logic is still required.

Optional Feature:
- Macro: ADDER2_BIST_STOP_ON_FAIL_EN.
- Defined:
  - The first mismatch in CHECK goes directly to FINISH. done pulses the next cycle with pass=0 and err_count=1.
  - a/b remain on the failing vector.
- Undefined:
  - The sweep always runs all vectors. err_count reflects all mismatches.

Test Plan:
- Correct adder model; rst, then start pulse -> busy for 32 cycles, done pulse at cycle 33, pass=1, err_count=0. a/b sequence 00/00,00/01,00/10,00/11,01/00 ... 11/11.
- Faulty model forcing y=0 when a=2'b01,b=2'b10 -> pass=0, err_count=1, fail_a=01, fail_b=10, fail_y=00.
- Model with y stuck at 00 -> err_count=12, since the 4 vectors whose sum mod 4 is 0 pass. fail_a=00, fail_b=01, fail_y=00.
- rst asserted at cycle 10 of a sweep -> next cycle busy=0, a=b=0, err_count=0, no done. A new start then runs a full 33-cycle sweep.
- start pulsed again at cycles 5 and 20 of a sweep -> ignored; done still at cycle 33 and vector order unchanged.
- With ADDER2_BIST_STOP_ON_FAIL_EN and y stuck at 00 -> done at cycle 5 (first CHECK of vector 00/01 at cycle 4). err_count=1, a=00, b=01 held.
